// File: rtl/freq_range_ctrl.sv
// freq_range_ctrl
//
// Autoranging gate sequencer for a two-digit frequency counter. Edges
// arriving as single-cycle strobes are counted over a gate window whose
// length is picked from four ranges. After each window the count is
// evaluated: in autorange mode the range is stepped up or down until the
// count lands in 10..99, otherwise the count is split into BCD tens/units by
// repeated subtraction and handed to the display driver with a load strobe.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   edge_pulse    one-cycle strobe per measured rising edge (already in clk)
//   auto_en       1 = autorange, 0 = use manual_range
//   manual_range  range used when auto_en = 0
//   hold          1 = suppress load; display freezes, measuring continues
//   tens, units   BCD digits of the displayed result
//   range_out     range of the window that produced the displayed digits
//   overflow      displayed result saturated at 99
//   load          one-cycle strobe, asserted in the cycle the outputs update
module freq_range_ctrl #(
  parameter int unsigned GATE0 = 12000,
  parameter int unsigned GATE1 = 1200,
  parameter int unsigned GATE2 = 120,
  parameter int unsigned GATE3 = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edge_pulse,
  input  logic       auto_en,
  input  logic [1:0] manual_range,
  input  logic       hold,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] range_out,
  output logic       overflow,
  output logic       load
);

  typedef enum logic [2:0] {COUNT, EVAL, TENS, UNITS, LOAD} state_t;

  state_t      state_reg, state_next;
  logic [15:0] gate_cnt_reg, gate_cnt_next;
  logic [15:0] edge_cnt_reg, edge_cnt_next;
  logic [1:0]  range_reg, range_next;

  // Result being assembled during conversion; copied to the outputs in LOAD.
  logic [3:0]  tens_pend_reg, tens_pend_next;
  logic [3:0]  units_pend_reg, units_pend_next;
  logic        ovf_pend_reg, ovf_pend_next;

  // Registered outputs.
  logic [3:0]  tens_reg, tens_next;
  logic [3:0]  units_reg, units_next;
  logic [1:0]  range_out_reg, range_out_next;
  logic        overflow_reg, overflow_next;
  logic        load_reg, load_next;

  // Gate length lookup, indexed by the active range.
  logic [15:0] gate_table [4];
  logic [15:0] gate_len;

  for (genvar gi = 0; gi < 4; gi++) begin : g_gate
    localparam int unsigned LEN = (gi == 0) ? GATE0 :
                                  (gi == 1) ? GATE1 :
                                  (gi == 2) ? GATE2 : GATE3;
    assign gate_table[gi] = 16'(LEN);
  end

  assign gate_len = gate_table[range_reg];

  logic too_high;
  logic too_low;

  assign too_high = (edge_cnt_reg > 16'd99);
  assign too_low  = (edge_cnt_reg < 16'd10);

  always_comb begin
    state_next      = state_reg;
    gate_cnt_next   = gate_cnt_reg;
    edge_cnt_next   = edge_cnt_reg;
    range_next      = range_reg;
    tens_pend_next  = tens_pend_reg;
    units_pend_next = units_pend_reg;
    ovf_pend_next   = ovf_pend_reg;
    tens_next       = tens_reg;
    units_next      = units_reg;
    range_out_next  = range_out_reg;
    overflow_next   = overflow_reg;
    load_next       = 1'b0;

    case (state_reg)
      COUNT: begin
        gate_cnt_next = gate_cnt_reg + 16'd1;
        // The final cycle of the window still counts its edge.
        if (edge_pulse && (edge_cnt_reg != 16'hFFFF)) begin
          edge_cnt_next = edge_cnt_reg + 16'd1;
        end
        if (gate_cnt_reg == gate_len - 16'd1) begin
          gate_cnt_next = 16'd0;
          state_next    = EVAL;
        end
      end

      EVAL: begin
        if (auto_en) begin
          if (too_high && (range_reg != 2'd3)) begin
            range_next    = range_reg + 2'd1;
            edge_cnt_next = 16'd0;
            state_next    = COUNT;
          end else if (too_low && (range_reg != 2'd0)) begin
            range_next    = range_reg - 2'd1;
            edge_cnt_next = 16'd0;
            state_next    = COUNT;
          end else if (too_high) begin
            // Shortest window and still above 99: saturate the display.
            ovf_pend_next   = 1'b1;
            tens_pend_next  = 4'd9;
            units_pend_next = 4'd9;
            state_next      = LOAD;
          end else begin
            state_next = TENS;
          end
        end else begin
          if (manual_range != range_reg) begin
            // Window was measured at the wrong range; discard it.
            range_next    = manual_range;
            edge_cnt_next = 16'd0;
            state_next    = COUNT;
          end else if (too_high) begin
            ovf_pend_next   = 1'b1;
            tens_pend_next  = 4'd9;
            units_pend_next = 4'd9;
            state_next      = LOAD;
          end else begin
            state_next = TENS;
          end
        end
      end

      TENS: begin
        // One subtraction per cycle; count is <= 99 here, so at most 9.
        if (edge_cnt_reg >= 16'd10) begin
          edge_cnt_next  = edge_cnt_reg - 16'd10;
          tens_pend_next = tens_pend_reg + 4'd1;
        end else begin
          state_next = UNITS;
        end
      end

      UNITS: begin
        units_pend_next = edge_cnt_reg[3:0];
        state_next      = LOAD;
      end

      LOAD: begin
        if (!hold) begin
          load_next      = 1'b1;
          tens_next      = tens_pend_reg;
          units_next     = units_pend_reg;
          range_out_next = range_reg;
          overflow_next  = ovf_pend_reg;
        end
        edge_cnt_next   = 16'd0;
        tens_pend_next  = 4'd0;
        units_pend_next = 4'd0;
        ovf_pend_next   = 1'b0;
        state_next      = COUNT;
      end

      default: begin
        state_next    = COUNT;
        gate_cnt_next = 16'd0;
        edge_cnt_next = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= COUNT;
      gate_cnt_reg   <= 16'd0;
      edge_cnt_reg   <= 16'd0;
      range_reg      <= 2'd0;
      tens_pend_reg  <= 4'd0;
      units_pend_reg <= 4'd0;
      ovf_pend_reg   <= 1'b0;
      tens_reg       <= 4'd0;
      units_reg      <= 4'd0;
      range_out_reg  <= 2'd0;
      overflow_reg   <= 1'b0;
      load_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gate_cnt_reg   <= gate_cnt_next;
      edge_cnt_reg   <= edge_cnt_next;
      range_reg      <= range_next;
      tens_pend_reg  <= tens_pend_next;
      units_pend_reg <= units_pend_next;
      ovf_pend_reg   <= ovf_pend_next;
      tens_reg       <= tens_next;
      units_reg      <= units_next;
      range_out_reg  <= range_out_next;
      overflow_reg   <= overflow_next;
      load_reg       <= load_next;
    end
  end

  assign tens      = tens_reg;
  assign units     = units_reg;
  assign range_out = range_out_reg;
  assign overflow  = overflow_reg;
  assign load      = load_reg;

endmodule

// File: tb/tb_freq_range_ctrl.sv
// Testbench for freq_range_ctrl with default gate lengths.
// Edge stimulus is a periodic burst pattern: within every gen_period cycles
// the first gen_burst cycles carry an edge strobe. All periods used divide
// the gate lengths of the ranges they are measured at, so each window holds
// an exact, hand-computable number of edges.
module tb_freq_range_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       edge_pulse = 1'b0;
  logic       auto_en = 1'b1;
  logic [1:0] manual_range = 2'd0;
  logic       hold = 1'b0;
  logic [3:0] tens;
  logic [3:0] units;
  logic [1:0] range_out;
  logic       overflow;
  logic       load;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int gen_period = 0;
  int gen_burst = 0;
  int gen_phase = 0;
  int load_cyc = 0;

  freq_range_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .edge_pulse   (edge_pulse),
    .auto_en      (auto_en),
    .manual_range (manual_range),
    .hold         (hold),
    .tens         (tens),
    .units        (units),
    .range_out    (range_out),
    .overflow     (overflow),
    .load         (load)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle (negedge) and drive that cycle's edge strobe.
  task automatic step();
    @(negedge clk);
    cyc++;
    edge_pulse = (gen_period != 0) && (gen_phase < gen_burst);
    gen_phase++;
    if (gen_phase >= gen_period) gen_phase = 0;
  endtask

  // Switch pattern; the current cycle becomes phase 0 of the new pattern.
  task automatic set_gen(input int p, input int b);
    gen_period = p;
    gen_burst  = b;
    edge_pulse = (p != 0) && (b > 0);
    gen_phase  = 1;
    if (gen_phase >= gen_period) gen_phase = 0;
  endtask

  task automatic run_until_load(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (load === 1'b1) begin
        seen = 1'b1;
        load_cyc = cyc;
        $display("load @%0d: tens=%0d units=%0d range_out=%0d overflow=%0d",
                 cyc, tens, units, range_out, overflow);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_gen(20, 1);
    repeat (3) step();
    compared++;
    if (tens !== 4'd0) begin mismatched++; $display("FAIL reset_tens: got %0d want 0", tens); end
    compared++;
    if (units !== 4'd0) begin mismatched++; $display("FAIL reset_units: got %0d want 0", units); end
    compared++;
    if (range_out !== 2'd0) begin mismatched++; $display("FAIL reset_range: got %0d want 0", range_out); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    compared++;
    if (load !== 1'b0) begin mismatched++; $display("FAIL reset_load: got %0b want 0", load); end
  endtask

  // Edge every 20: range 0 sees 600 (step up), range 1 sees 60.
  task automatic test_autorange_up();
    int base;
    bit seen;
    reset = 1'b0;
    base = cyc;  // first window cycle
    // range 0 window base..base+11999, EVAL, range 1 window ends base+13200
    run_until_load(14000, seen);
    compared++;
    if (!seen) begin mismatched++; $display("FAIL up_seen: got no load want load"); end
    compared++;
    if (load_cyc <= base + 13200 || load_cyc > base + 13213) begin
      mismatched++;
      $display("FAIL up_latency: got offset %0d want 13201..13213", load_cyc - base);
    end
    compared++;
    if (tens !== 4'd6) begin mismatched++; $display("FAIL up_tens: got %0d want 6", tens); end
    compared++;
    if (units !== 4'd0) begin mismatched++; $display("FAIL up_units: got %0d want 0", units); end
    compared++;
    if (range_out !== 2'd1) begin mismatched++; $display("FAIL up_range: got %0d want 1", range_out); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL up_overflow: got %0b want 0", overflow); end
  endtask

  // Edge every 2: range 1 sees 600 (step up), range 2 sees 60, then steady.
  task automatic test_step_two();
    int l0;
    int prev;
    bit seen;
    l0 = cyc;
    set_gen(2, 1);
    run_until_load(1500, seen);
    compared++;
    if (!seen || load_cyc <= l0 + 1320 || load_cyc > l0 + 1333) begin
      mismatched++;
      $display("FAIL two_first_load: got seen=%0b offset %0d want 1321..1333", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd6 || units !== 4'd0 || range_out !== 2'd2 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL two_values: got %0d%0d r%0d o%0b want 60 r2 o0", tens, units, range_out, overflow);
    end
    for (int k = 0; k < 2; k++) begin
      prev = load_cyc;
      step();
      compared++;
      if (load !== 1'b0) begin mismatched++; $display("FAIL two_load_width: got %0b want 0", load); end
      run_until_load(200, seen);
      // 120 window + EVAL + 7 TENS + UNITS + LOAD
      compared++;
      if (!seen || (load_cyc - prev) < 129 || (load_cyc - prev) > 130) begin
        mismatched++;
        $display("FAIL two_period: got seen=%0b spacing %0d want 129..130", seen, load_cyc - prev);
      end
      compared++;
      if (tens !== 4'd6 || units !== 4'd0 || range_out !== 2'd2) begin
        mismatched++;
        $display("FAIL two_steady: got %0d%0d r%0d want 60 r2", tens, units, range_out);
      end
    end
  endtask

  // Edge every 40: range 2 sees 3 (step down), range 1 sees 30.
  task automatic test_rate_drop();
    int l0;
    bit seen;
    l0 = cyc;
    set_gen(40, 1);
    run_until_load(1500, seen);
    compared++;
    if (!seen || load_cyc <= l0 + 1320 || load_cyc > l0 + 1333) begin
      mismatched++;
      $display("FAIL drop_load: got seen=%0b offset %0d want 1321..1333", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd3 || units !== 4'd0 || range_out !== 2'd1 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL drop_values: got %0d%0d r%0d o%0b want 30 r1 o0", tens, units, range_out, overflow);
    end
  endtask

  // 3 edges per 80 cycles: 45 per range-1 window. Hold across 3 windows.
  task automatic test_hold();
    int l0;
    int loads;
    int bad;
    bit seen;
    l0 = cyc;
    set_gen(80, 3);
    run_until_load(1400, seen);
    compared++;
    if (!seen || load_cyc <= l0 + 1200 || load_cyc > l0 + 1213) begin
      mismatched++;
      $display("FAIL hold_first: got seen=%0b offset %0d want 1201..1213", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd4 || units !== 4'd5 || range_out !== 2'd1) begin
      mismatched++;
      $display("FAIL hold_first_values: got %0d%0d r%0d want 45 r1", tens, units, range_out);
    end
    l0 = load_cyc;
    hold = 1'b1;
    loads = 0;
    bad = 0;
    repeat (3650) begin
      step();
      if (load !== 1'b0) loads++;
      if (tens !== 4'd4 || units !== 4'd5 || range_out !== 2'd1) bad++;
    end
    compared++;
    if (loads != 0) begin mismatched++; $display("FAIL hold_loads: got %0d want 0", loads); end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL hold_frozen: got %0d changed cycles want 0", bad); end
    hold = 1'b0;
    // windows repeat every 1208 cycles; the fourth one loads again
    run_until_load(1300, seen);
    compared++;
    if (!seen || (load_cyc - l0) < 4820 || (load_cyc - l0) > 4832) begin
      mismatched++;
      $display("FAIL hold_release: got seen=%0b offset %0d want 4820..4832", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd4 || units !== 4'd5 || range_out !== 2'd1) begin
      mismatched++;
      $display("FAIL hold_release_values: got %0d%0d r%0d want 45 r1", tens, units, range_out);
    end
  endtask

  // 87 edges per 120 cycles: range 1 sees 870, range 2 sees 87 -> TENS
  // runs cycles 1322..1330 after the last load. Reset lands at 1325.
  task automatic test_reset_mid();
    int l0;
    int loads;
    int base;
    bit seen;
    l0 = cyc;
    set_gen(120, 87);
    loads = 0;
    repeat (1325) begin
      step();
      if (load !== 1'b0) loads++;
    end
    compared++;
    if (loads != 0) begin mismatched++; $display("FAIL rmid_preload: got %0d loads want 0", loads); end
    compared++;
    if (tens !== 4'd4 || units !== 4'd5) begin
      mismatched++;
      $display("FAIL rmid_before: got %0d%0d want 45", tens, units);
    end
    reset = 1'b1;
    step();
    compared++;
    if (tens !== 4'd0 || units !== 4'd0 || range_out !== 2'd0 || overflow !== 1'b0 || load !== 1'b0) begin
      mismatched++;
      $display("FAIL rmid_cleared: got %0d%0d r%0d o%0b l%0b want 00 r0 o0 l0",
               tens, units, range_out, overflow, load);
    end
    step();
    reset = 1'b0;
    base = cyc;
    // restart at range 0: 8700 up, 870 up, 87 at range 2 ending base+13321
    run_until_load(13500, seen);
    compared++;
    if (!seen || load_cyc <= base + 13321 || load_cyc > base + 13334) begin
      mismatched++;
      $display("FAIL rmid_restart: got seen=%0b offset %0d want 13322..13334", seen, load_cyc - base);
    end
    compared++;
    if (tens !== 4'd8 || units !== 4'd7 || range_out !== 2'd2 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL rmid_values: got %0d%0d r%0d o%0b want 87 r2 o0", tens, units, range_out, overflow);
    end
  endtask

  // Manual mode: adopt range 3 (12 edges -> 12), then range 0 with an edge
  // every 20 cycles (600 -> saturate 99 with overflow).
  task automatic test_manual();
    int l0;
    bit seen;
    l0 = cyc;
    auto_en = 1'b0;
    manual_range = 2'd3;
    set_gen(1, 1);
    // range 2 window discarded at EVAL l0+120, range 3 window ends l0+132
    run_until_load(200, seen);
    compared++;
    if (!seen || load_cyc <= l0 + 132 || load_cyc > l0 + 145) begin
      mismatched++;
      $display("FAIL man_r3_load: got seen=%0b offset %0d want 133..145", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd1 || units !== 4'd2 || range_out !== 2'd3 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL man_r3_values: got %0d%0d r%0d o%0b want 12 r3 o0", tens, units, range_out, overflow);
    end
    l0 = load_cyc;
    manual_range = 2'd0;
    set_gen(20, 1);
    // range 3 window discarded at EVAL l0+12, range 0 window ends l0+12012
    run_until_load(12100, seen);
    compared++;
    if (!seen || load_cyc <= l0 + 12012 || load_cyc > l0 + 12025) begin
      mismatched++;
      $display("FAIL man_ovf_load: got seen=%0b offset %0d want 12013..12025", seen, load_cyc - l0);
    end
    compared++;
    if (tens !== 4'd9 || units !== 4'd9 || range_out !== 2'd0 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL man_ovf_values: got %0d%0d r%0d o%0b want 99 r0 o1", tens, units, range_out, overflow);
    end
    auto_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_autorange_up();
    test_step_two();
    test_rate_drop();
    test_hold();
    test_reset_mid();
    test_manual();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
